// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: control bundle layout and base opcodes.
package rv_pkg;

    // Control bundle: {jump[1:0], branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
    localparam int unsigned CTRL_W          = 10;
    localparam int unsigned CTRL_JUMP_HI    = 9;
    localparam int unsigned CTRL_JUMP_LO    = 8;
    localparam int unsigned CTRL_BRANCH     = 7;
    localparam int unsigned CTRL_MEM_READ   = 6;
    localparam int unsigned CTRL_MEM_TO_REG = 5;
    localparam int unsigned CTRL_ALU_OP_HI  = 4;
    localparam int unsigned CTRL_ALU_OP_LO  = 3;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_ALU_SRC    = 1;
    localparam int unsigned CTRL_REG_WRITE  = 0;

    // RV32I base opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // True when the bundle describes a load
    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   i_ex_valid, i_ex_mem_read, i_ex_rd : load currently in EX
//   i_id_valid, i_id_rs1, i_id_rs2     : consumer in ID
//   o_load_use_c                       : ID must wait one cycle
module hazard_unit #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    output logic              o_load_use_c
);

    logic w_rd_nonzero;
    logic w_src_match;

    assign w_rd_nonzero = (i_ex_rd != '0);
    // rs2 is compared even for I-type consumers: a spurious stall is cheaper than decoding format here
    assign w_src_match  = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
    assign o_load_use_c = i_ex_valid & i_ex_mem_read & i_id_valid & w_rd_nonzero & w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and
// saturating stall/flush event counters.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   id_*                            : decoded instruction from ID
//   ex_flush                        : taken branch/jump resolved in EX
//   hold                            : downstream freeze
//   stall_if_id                     : combinational freeze request for PC and IF/ID
//   ex_*                            : registered EX slot
//   stall_count, flush_count        : saturating event counters
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_funct,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    input  logic              hold,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [3:0]        ex_funct,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_pc;
    logic [DATA_W-1:0] r_ex_rs1_data;
    logic [DATA_W-1:0] r_ex_rs2_data;
    logic [DATA_W-1:0] r_ex_imm;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic [REG_AW-1:0] r_ex_rd;
    logic [3:0]        r_ex_funct;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    logic              w_load_use;

    // Hazard detection against the instruction currently held in EX
    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .i_ex_valid    (r_ex_valid),
        .i_ex_mem_read (ctrl_is_load(r_ex_ctrl)),
        .i_ex_rd       (r_ex_rd),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .o_load_use_c  (w_load_use)
    );

    // A flush squashes ID anyway, so front-end freezing is pointless then
    assign stall_if_id = (w_load_use | hold) & ~ex_flush;

    // EX slot: reset > flush > hold > bubble > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_funct    <= '0;
        end else if (ex_flush) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_funct    <= '0;
        end else if (hold) begin
            r_ex_valid    <= r_ex_valid;
        end else if (w_load_use) begin
            // Bubble: data fields are left as-is, only valid/control are killed
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_ctrl     <= id_valid ? id_ctrl : '0;
            r_ex_pc       <= id_pc;
            r_ex_rs1_data <= id_rs1_data;
            r_ex_rs2_data <= id_rs2_data;
            r_ex_imm      <= id_imm;
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
            r_ex_rd       <= id_rd;
            r_ex_funct    <= id_funct;
        end
    end

    // Saturating event counters, same priority as the slot update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (ex_flush) begin
            if (r_flush_count != CNT_MAX) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end else if (!hold && w_load_use) begin
            if (r_stall_count != CNT_MAX) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_rs1_data = r_ex_rs1_data;
    assign ex_rs2_data = r_ex_rs2_data;
    assign ex_imm      = r_ex_imm;
    assign ex_rs1      = r_ex_rs1;
    assign ex_rs2      = r_ex_rs2;
    assign ex_rd       = r_ex_rd;
    assign ex_funct    = r_ex_funct;
    assign ex_ctrl     = r_ex_ctrl;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a behavioural model; a second instance with 3-bit counters covers saturation.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [DW-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0]    id_funct;
    logic [9:0]    id_ctrl;
    logic          ex_flush, hold;

    logic          stall_if_id, ex_valid;
    logic [DW-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0]    ex_funct;
    logic [9:0]    ex_ctrl;
    logic [15:0]   stall_count, flush_count;

    logic          s_stall_if_id, s_ex_valid;
    logic [DW-1:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [AW-1:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [3:0]    s_ex_funct;
    logic [9:0]    s_ex_ctrl;
    logic [2:0]    s_stall_count, s_flush_count;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_ctrl(id_ctrl), .ex_flush(ex_flush), .hold(hold),
        .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_ctrl(ex_ctrl), .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_stage #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_ctrl(id_ctrl), .ex_flush(ex_flush), .hold(hold),
        .stall_if_id(s_stall_if_id), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
        .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
        .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct(s_ex_funct),
        .ex_ctrl(s_ex_ctrl), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the EX slot
    bit            m_valid;
    logic [9:0]    m_ctrl;
    logic [DW-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    logic [3:0]    m_funct;
    int            m_stalls, m_flushes, m_sat_stalls, m_sat_flushes;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_load_use();
        bit is_load;
        is_load = m_ctrl[6];
        return m_valid && is_load && id_valid && (m_rd != 0) &&
               ((m_rd == id_rs1) || (m_rd == id_rs2));
    endfunction

    function automatic bit model_stall();
        return (model_load_use() || hold) && !ex_flush;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic clear_slot();
        m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0;
    endtask

    task automatic model_update();
        bit lu;
        lu = model_load_use();
        if (reset) begin
            clear_slot();
            m_stalls = 0; m_flushes = 0; m_sat_stalls = 0; m_sat_flushes = 0;
        end else if (ex_flush) begin
            clear_slot();
            m_flushes     = sat_inc(m_flushes, 65535);
            m_sat_flushes = sat_inc(m_sat_flushes, 7);
        end else if (hold) begin
            // slot frozen
        end else if (lu) begin
            m_valid = 0;
            m_ctrl  = 0;
            m_stalls     = sat_inc(m_stalls, 65535);
            m_sat_stalls = sat_inc(m_sat_stalls, 7);
        end else begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? id_ctrl : 10'd0;
            m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct;
        end
    endtask

    task automatic check_slot();
        check("ex_valid",    ex_valid,    m_valid);
        check("ex_ctrl",     ex_ctrl,     m_ctrl);
        check("ex_pc",       ex_pc,       m_pc);
        check("ex_rs1_data", ex_rs1_data, m_rs1d);
        check("ex_rs2_data", ex_rs2_data, m_rs2d);
        check("ex_imm",      ex_imm,      m_imm);
        check("ex_rs1",      ex_rs1,      m_rs1);
        check("ex_rs2",      ex_rs2,      m_rs2);
        check("ex_rd",       ex_rd,       m_rd);
        check("ex_funct",    ex_funct,    m_funct);
        check("stall_count", stall_count, m_stalls);
        check("flush_count", flush_count, m_flushes);
        check("sat_stall_count", s_stall_count, m_sat_stalls);
        check("sat_flush_count", s_flush_count, m_sat_flushes);
    endtask

    // One clock: check combinational stall mid-cycle, then registered state after the edge
    task automatic tick();
        @(negedge clk);
        check("stall_if_id", stall_if_id, model_stall());
        @(posedge clk);
        model_update();
        #1;
        check_slot();
    endtask

    task automatic drive_instr(input logic [DW-1:0] pc, input logic [9:0] ctrl,
                               input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic [AW-1:0] rd);
        id_valid = 1'b1; id_pc = pc; id_ctrl = ctrl;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_funct = 4'($urandom);
    endtask

    task automatic randomize_id();
        id_valid    = ($urandom_range(0, 9) != 0);
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_rs1      = 5'($urandom_range(0, 3));
        id_rs2      = 5'($urandom_range(0, 3));
        id_rd       = 5'($urandom_range(0, 3));
        id_funct    = 4'($urandom);
        id_ctrl     = 10'($urandom);
        if ($urandom_range(0, 1) == 0) id_ctrl[6] = 1'b1;
    endtask

    localparam logic [9:0] CTRL_ALU = 10'b0000010001;
    localparam logic [9:0] CTRL_LW  = 10'b0001100011;

    logic [DW-1:0] saved_pc;
    logic [9:0]    saved_ctrl;

    initial begin
        reset = 1'b1; ex_flush = 1'b0; hold = 1'b0;
        randomize_id();

        // Reset: two cycles with random ID inputs
        @(posedge clk);
        model_update();
        #1;
        randomize_id();
        tick();
        check("reset_valid", ex_valid, 1'b0);
        check("reset_ctrl", ex_ctrl, 10'd0);
        check("reset_stall_cnt", stall_count, 16'd0);
        check("reset_flush_cnt", flush_count, 16'd0);
        check("reset_stall_if_id", stall_if_id, 1'b0);

        // Capture
        reset = 1'b0;
        drive_instr(32'h100, CTRL_ALU, 5'd1, 5'd2, 5'd7);
        tick();
        check("cap_pc", ex_pc, 32'h100);
        check("cap_ctrl", ex_ctrl, CTRL_ALU);
        check("cap_rd", ex_rd, 5'd7);
        check("cap_valid", ex_valid, 1'b1);

        // Load-use on rs1: one stall cycle then release
        drive_instr(32'h104, CTRL_LW, 5'd1, 5'd3, 5'd5);
        tick();
        drive_instr(32'h108, CTRL_ALU, 5'd5, 5'd9, 5'd6);
        #1;
        check("lu_stall", stall_if_id, 1'b1);
        tick();
        check("lu_bubble_valid", ex_valid, 1'b0);
        check("lu_bubble_ctrl", ex_ctrl, 10'd0);
        check("lu_stall_cnt", stall_count, 16'd1);
        check("lu_released", stall_if_id, 1'b0);
        tick();
        check("lu_consumer_pc", ex_pc, 32'h108);

        // Load to x0 never stalls
        drive_instr(32'h10c, CTRL_LW, 5'd1, 5'd3, 5'd0);
        tick();
        drive_instr(32'h110, CTRL_ALU, 5'd0, 5'd0, 5'd6);
        #1;
        check("x0_no_stall", stall_if_id, 1'b0);
        tick();

        // Flush beats load-use
        drive_instr(32'h114, CTRL_LW, 5'd1, 5'd3, 5'd5);
        tick();
        drive_instr(32'h118, CTRL_ALU, 5'd5, 5'd9, 5'd6);
        ex_flush = 1'b1;
        #1;
        check("flush_no_stall", stall_if_id, 1'b0);
        tick();
        ex_flush = 1'b0;
        check("flush_valid", ex_valid, 1'b0);
        check("flush_cnt", flush_count, 16'd1);
        check("flush_stall_cnt", stall_count, 16'd1);

        // Hold for three cycles while ID changes
        drive_instr(32'h200, CTRL_ALU, 5'd1, 5'd2, 5'd3);
        tick();
        saved_pc = ex_pc;
        saved_ctrl = ex_ctrl;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_instr(32'h300 + 32'(i * 4), CTRL_LW, 5'd4, 5'd5, 5'd6);
            #1;
            check("hold_stall", stall_if_id, 1'b1);
            tick();
            check("hold_pc", ex_pc, saved_pc);
            check("hold_ctrl", ex_ctrl, saved_ctrl);
        end
        hold = 1'b0;
        drive_instr(32'h400, CTRL_ALU, 5'd1, 5'd2, 5'd3);
        tick();
        check("hold_release_pc", ex_pc, 32'h400);

        // Ten back-to-back flushes saturate the 3-bit counter
        ex_flush = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomize_id();
            hold = ($urandom_range(0, 1) == 0);
            tick();
        end
        ex_flush = 1'b0;
        hold = 1'b0;
        check("sat_flush_stuck", s_flush_count, 3'd7);
        check("wide_flush_count", flush_count, 16'd11);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            randomize_id();
            ex_flush = ($urandom_range(0, 9) == 0);
            hold     = ($urandom_range(0, 6) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline boundary for the 5-stage RV32I core. It registers the decoded operands and the 10-bit control bundle from the main control decoder into EX. It also performs load-use hazard detection, inserts bubbles, and applies branch/jump flushes and downstream holds. It keeps saturating stall and flush event counters for the performance CSRs.

Parameters:
DATA_W, 32, datapath/PC/immediate width
REG_AW, 5, register index width
CNT_W, 16, width of each event counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_W  PC of ID instruction
id_rs1_data, id_rs2_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_AW  register indices
id_funct  in  4  {instr[30], funct3}
id_ctrl  in  10  {jump[1:0], branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
ex_flush  in  1  taken branch/jump resolved in EX
hold  in  1  downstream freeze (memory wait)
stall_if_id  out  1  freeze PC and IF/ID (combinational)
ex_valid  out  1  EX slot valid
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  DATA_W  registered copies
ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered indices
ex_funct  out  4  registered funct
ex_ctrl  out  10  registered control bundle, same bit order as id_ctrl
stall_count, flush_count  out  CNT_W  saturating event counters

Behaviour:
- Reset (sync, active-high): ex_valid=0, ex_ctrl=0, all data/index outputs=0, both counters=0. Reset overrides every other input.
- load_use = ex_valid & ex_ctrl.mem_read & id_valid & (ex_rd!=0) & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
- The rs2 compare is deliberately conservative and is also applied to I-type instructions.
- stall_if_id = (load_use | hold) & ~ex_flush. It is purely combinational from current register state and inputs.
- Per-edge update priority, highest first:
  1. reset.
  2. ex_flush: ex_valid=0 and ex_ctrl=0. Data fields are don't-care but are driven to 0. flush_count increments.
  3. hold: all ex_* registers keep their values. Counters are unchanged.
  4. load_use: bubble. ex_valid=0, ex_ctrl=0, data fields unchanged. stall_count increments.
  5. Normal: capture all id_* fields. ex_valid=id_valid. ex_ctrl=id_ctrl if id_valid, else 0.
- Latency: one cycle from ID to EX. No combinational path from id_* to ex_*.
- A bubble always has ex_ctrl=0, so reg_write, mem_write and jump are inactive downstream.
- Counters saturate at 2^CNT_W-1 and never wrap.
- If ex_flush and load_use are both high, flush wins: only flush_count increments and stall_if_id=0.
- If ex_flush and hold are both high, flush wins and the slot is cleared.
- A load-use stall lasts exactly one cycle. After the bubble, ex_valid=0 so load_use deasserts.
- Reset asserted mid-stall clears everything. stall_if_id drops in the cycle after reset is sampled.

Decomposition:
- Shared package rv_pkg holds:
  - CTRL_W=10.
  - Bit-index constants CTRL_JUMP_HI/LO, CTRL_BRANCH, CTRL_MEM_READ, CTRL_MEM_TO_REG, CTRL_ALU_OP_HI/LO, CTRL_MEM_WRITE, CTRL_ALU_SRC, CTRL_REG_WRITE.
  - Opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR.
- One combinational sub-module, hazard_unit, computes load_use. Registers and counters stay in id_ex_stage.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> ex_valid=0, ex_ctrl=0, counters=0, stall_if_id=0.
- Capture: id_valid=1, id_pc=0x100, id_ctrl=10'b00_000_10_001, id_rd=7 -> next cycle ex_pc=0x100, ex_ctrl=10'b0000010001, ex_rd=7, ex_valid=1.
- Load-use: EX holds lw x5 (ctrl 10'b00_011_00_011, ex_rd=5); ID has rs1=5 -> stall_if_id=1 for exactly one cycle, next ex_ctrl=0 and ex_valid=0, stall_count=1. Repeat with ex_rd=0 -> no stall.
- Flush vs hazard: load-use condition plus ex_flush=1 -> stall_if_id=0, next ex_valid=0, flush_count=1, stall_count unchanged.
- Hold: hold=1 for 3 cycles while id_* changes -> ex_* constant, stall_if_id=1, counters unchanged; capture resumes on the release edge.
- Saturation: with CNT_W=3, force 10 back-to-back flushes -> flush_count sticks at 7.
